// File: rtl/rab_cfg_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : rab_cfg_pkg
//  Description : Shared constants and types for the RAB configuration /
//                miss-handling block: register word offsets, MH_STAT bit
//                positions, AXI response codes, FSM state encodings and the
//                default-width miss queue entry layout.
//  Revision    : 1.0 - initial release
// ============================================================================
package rab_cfg_pkg;

    // Register map, expressed as 32-bit word offsets (byte address >> 2)
    localparam int c_OFF_MH_ADDR  = 0;
    localparam int c_OFF_MH_ID    = 1;
    localparam int c_OFF_MH_STAT  = 2;
    localparam int c_OFF_RSVD     = 3;
    localparam int c_OFF_CFG_BASE = 4;

    // MH_STAT / MH_ID / MH_ADDR field positions
    localparam int c_STAT_CNT_W      = 16;
    localparam int c_STAT_STICKY_BIT = 16;
    localparam int c_STAT_IRQEN_BIT  = 17;
    localparam int c_ID_EMPTY_BIT    = 31;
    localparam int c_ADDR_EMPTY_BIT  = 0;

    localparam logic [1:0] c_RESP_OKAY   = 2'b00;
    localparam logic [1:0] c_RESP_SLVERR = 2'b10;

    // Port-number field width; a single port still needs one bit
    function automatic int rab_pw(input int n_ports);
        return (n_ports > 1) ? $clog2(n_ports) : 1;
    endfunction

    // Queue entry layout at the default build widths (4 ports, 10b ID, 20b page)
    typedef struct packed {
        logic [1:0]  port;
        logic [9:0]  id;
        logic [19:0] addr;
    } mh_entry_t;

    typedef enum logic [0:0] {
        WR_COLLECT = 1'b0,
        WR_RESP    = 1'b1
    } wr_state_t;

    typedef enum logic [0:0] {
        RD_IDLE = 1'b0,
        RD_RESP = 1'b1
    } rd_state_t;

endpackage
`default_nettype wire

// File: rtl/rab_mh_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : rab_mh_fifo
//  Description : Synchronous FIFO for the miss-handling queue. Push into a
//                full FIFO and pop from an empty FIFO are ignored. Full and
//                empty flags are registered.
//  Ports       : clk, rst_n (sync, active-low), i_push/i_data,
//                i_pop/o_data (head, show-ahead), o_full, o_empty, o_count
//  Revision    : 1.0 - initial release
// ============================================================================
module rab_mh_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             r_full;
    logic             r_empty;
    logic             w_do_push;
    logic             w_do_pop;
    logic [AW:0]      w_count_nxt;

    assign w_do_push   = i_push && !r_full;
    assign w_do_pop    = i_pop && !r_empty;
    assign w_count_nxt = r_count + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == (AW+1)'(DEPTH));
            r_empty <= (w_count_nxt == '0);
        end
    end

    // Storage carries no reset; validity is tracked by the pointers/count
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr] <= i_data;
    end

    assign o_data  = r_mem[r_rptr];
    assign o_full  = r_full;
    assign o_empty = r_empty;
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/axi_rab_cfg_mh.sv
`default_nettype none
// ============================================================================
//  Module      : axi_rab_cfg_mh
//  Description : AXI4-Lite slave holding the RAB slice configuration
//                registers plus a multi-port miss-handling queue. N_PORTS
//                RAB ports push misses through a round-robin arbiter into one
//                FIFO that software drains over AXI-Lite.
//  Ports       : s_axi_aclk / s_axi_aresetn (sync, active-low)
//                s_axi_aw*/w*/b*/ar*/r*  AXI4-Lite slave
//                cfg_regs      config register contents
//                MissAddr_DI / MissId_DI / MissValid_SI / MissReady_SO
//                MhFifoFull_SO, MhIrq_SO
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_rab_cfg_mh
    import rab_cfg_pkg::*;
#(
    parameter int REG_ENTRIES         = 196,
    parameter int C_AXICFG_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH      = 32,
    parameter int MHR_WIDTH           = 20,
    parameter int MISS_ID_WIDTH       = 10,
    parameter int N_PORTS             = 4,
    parameter int MH_FIFO_DEPTH       = 16
) (
    input  logic                                      s_axi_aclk,
    input  logic                                      s_axi_aresetn,
    input  logic [AXI_ADDR_WIDTH-1:0]                 s_axi_awaddr,
    input  logic                                      s_axi_awvalid,
    output logic                                      s_axi_awready,
    input  logic [C_AXICFG_DATA_WIDTH-1:0]            s_axi_wdata,
    input  logic [C_AXICFG_DATA_WIDTH/8-1:0]          s_axi_wstrb,
    input  logic                                      s_axi_wvalid,
    output logic                                      s_axi_wready,
    output logic [1:0]                                s_axi_bresp,
    output logic                                      s_axi_bvalid,
    input  logic                                      s_axi_bready,
    input  logic [AXI_ADDR_WIDTH-1:0]                 s_axi_araddr,
    input  logic                                      s_axi_arvalid,
    output logic                                      s_axi_arready,
    output logic [C_AXICFG_DATA_WIDTH-1:0]            s_axi_rdata,
    output logic [1:0]                                s_axi_rresp,
    output logic                                      s_axi_rvalid,
    input  logic                                      s_axi_rready,
    output logic [REG_ENTRIES-1:0][AXI_ADDR_WIDTH-1:0] cfg_regs,
    input  logic [N_PORTS-1:0][AXI_ADDR_WIDTH-1:0]    MissAddr_DI,
    input  logic [N_PORTS-1:0][MISS_ID_WIDTH-1:0]     MissId_DI,
    input  logic [N_PORTS-1:0]                        MissValid_SI,
    output logic [N_PORTS-1:0]                        MissReady_SO,
    output logic                                      MhFifoFull_SO,
    output logic                                      MhIrq_SO
);

    localparam int PW     = rab_pw(N_PORTS);
    localparam int CNT_W  = $clog2(MH_FIFO_DEPTH) + 1;
    localparam int WORD_W = AXI_ADDR_WIDTH - 2;

    localparam logic [WORD_W-1:0] c_W_MH_ADDR  = WORD_W'(c_OFF_MH_ADDR);
    localparam logic [WORD_W-1:0] c_W_MH_ID    = WORD_W'(c_OFF_MH_ID);
    localparam logic [WORD_W-1:0] c_W_MH_STAT  = WORD_W'(c_OFF_MH_STAT);
    localparam logic [WORD_W-1:0] c_W_RSVD     = WORD_W'(c_OFF_RSVD);
    localparam logic [WORD_W-1:0] c_W_CFG_BASE = WORD_W'(c_OFF_CFG_BASE);
    localparam logic [WORD_W-1:0] c_W_CFG_END  = WORD_W'(c_OFF_CFG_BASE + REG_ENTRIES);

    // Entry layout at this instance's widths (matches mh_entry_t at defaults)
    typedef struct packed {
        logic [PW-1:0]            port;
        logic [MISS_ID_WIDTH-1:0] id;
        logic [MHR_WIDTH-1:0]     addr;
    } entry_t;

    wr_state_t                  r_wr_state, w_wr_state_nxt;
    rd_state_t                  r_rd_state, w_rd_state_nxt;
    logic                       r_aw_got, r_w_got;
    logic [WORD_W-1:0]          r_aw_word;
    logic [31:0]                r_wdata;
    logic [3:0]                 r_wstrb;
    logic [1:0]                 r_bresp;
    logic                       w_wr_commit, w_wr_err, w_wr_is_cfg, w_stat_wr;
    logic [WORD_W-1:0]          w_wr_idx, w_rd_word, w_rd_idx;
    logic                       w_rd_latch, w_rd_done, w_rd_err;
    logic [31:0]                r_rdata, w_rd_data;
    logic [1:0]                 r_rresp;
    logic                       r_rd_pop;
    logic [REG_ENTRIES-1:0][AXI_ADDR_WIDTH-1:0] r_cfg;
    logic                       r_sticky, r_irq_en, r_irq;
    logic [PW-1:0]              r_rr_ptr, w_grant_idx;
    logic                       w_push, w_pop, w_overflow;
    entry_t                     w_push_entry, w_head;
    logic                       w_fifo_full, w_fifo_empty;
    logic [CNT_W-1:0]           w_fifo_count;
    logic                       w_unused;

    // ------------------------------------------------------------------ write
    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_aresetn) r_wr_state <= WR_COLLECT;
        else                r_wr_state <= w_wr_state_nxt;
    end

    always_comb begin
        w_wr_state_nxt = r_wr_state;
        w_wr_commit    = 1'b0;
        case (r_wr_state)
            WR_COLLECT: if (r_aw_got && r_w_got) begin
                w_wr_commit    = 1'b1;
                w_wr_state_nxt = WR_RESP;
            end
            WR_RESP: if (s_axi_bready) w_wr_state_nxt = WR_COLLECT;
            default: w_wr_state_nxt = WR_COLLECT;
        endcase
    end

    assign s_axi_awready = (r_wr_state == WR_COLLECT) && !r_aw_got;
    assign s_axi_wready  = (r_wr_state == WR_COLLECT) && !r_w_got;
    assign s_axi_bvalid  = (r_wr_state == WR_RESP);
    assign s_axi_bresp   = r_bresp;

    assign w_wr_is_cfg = (r_aw_word >= c_W_CFG_BASE) && (r_aw_word < c_W_CFG_END);
    assign w_wr_err    = (r_aw_word >= c_W_CFG_END);
    assign w_wr_idx    = r_aw_word - c_W_CFG_BASE;
    assign w_stat_wr   = w_wr_commit && (r_aw_word == c_W_MH_STAT) && r_wstrb[2];

    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_aresetn) begin
            r_aw_got  <= 1'b0;
            r_w_got   <= 1'b0;
            r_aw_word <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_bresp   <= c_RESP_OKAY;
        end else begin
            if (s_axi_awvalid && s_axi_awready) begin
                r_aw_got  <= 1'b1;
                r_aw_word <= s_axi_awaddr[AXI_ADDR_WIDTH-1:2];
            end
            if (s_axi_wvalid && s_axi_wready) begin
                r_w_got <= 1'b1;
                r_wdata <= s_axi_wdata;
                r_wstrb <= s_axi_wstrb;
            end
            if (w_wr_commit) begin
                r_aw_got <= 1'b0;
                r_w_got  <= 1'b0;
                r_bresp  <= w_wr_err ? c_RESP_SLVERR : c_RESP_OKAY;
            end
        end
    end

    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_aresetn) begin
            r_cfg <= '0;
        end else begin
            for (int k = 0; k < REG_ENTRIES; k++) begin
                if (w_wr_commit && w_wr_is_cfg && (w_wr_idx == WORD_W'(k))) begin
                    for (int b = 0; b < 4; b++) begin
                        if (r_wstrb[b]) r_cfg[k][8*b +: 8] <= r_wdata[8*b +: 8];
                    end
                end
            end
        end
    end

    assign cfg_regs = r_cfg;

    // ------------------------------------------------------------------- read
    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_aresetn) r_rd_state <= RD_IDLE;
        else                r_rd_state <= w_rd_state_nxt;
    end

    always_comb begin
        w_rd_state_nxt = r_rd_state;
        w_rd_latch     = 1'b0;
        w_rd_done      = 1'b0;
        case (r_rd_state)
            RD_IDLE: if (s_axi_arvalid) begin
                w_rd_latch     = 1'b1;
                w_rd_state_nxt = RD_RESP;
            end
            RD_RESP: if (s_axi_rready) begin
                w_rd_done      = 1'b1;
                w_rd_state_nxt = RD_IDLE;
            end
            default: w_rd_state_nxt = RD_IDLE;
        endcase
    end

    assign s_axi_arready = (r_rd_state == RD_IDLE);
    assign s_axi_rvalid  = (r_rd_state == RD_RESP);
    assign s_axi_rdata   = r_rdata;
    assign s_axi_rresp   = r_rresp;

    assign w_rd_word = s_axi_araddr[AXI_ADDR_WIDTH-1:2];
    assign w_rd_idx  = w_rd_word - c_W_CFG_BASE;

    // Queue fields read as zero while empty so software never sees stale data
    always_comb begin
        w_rd_data = '0;
        w_rd_err  = 1'b0;
        if (w_rd_word == c_W_MH_ADDR) begin
            w_rd_data[c_ADDR_EMPTY_BIT] = w_fifo_empty;
            if (!w_fifo_empty) w_rd_data[31 -: MHR_WIDTH] = w_head.addr;
        end else if (w_rd_word == c_W_MH_ID) begin
            w_rd_data[c_ID_EMPTY_BIT] = w_fifo_empty;
            if (!w_fifo_empty) w_rd_data[MISS_ID_WIDTH+PW-1:0] = {w_head.port, w_head.id};
        end else if (w_rd_word == c_W_MH_STAT) begin
            w_rd_data[c_STAT_CNT_W-1:0]    = c_STAT_CNT_W'(w_fifo_count);
            w_rd_data[c_STAT_STICKY_BIT]   = r_sticky;
            w_rd_data[c_STAT_IRQEN_BIT]    = r_irq_en;
        end else if (w_rd_word == c_W_RSVD) begin
            w_rd_data = '0;
        end else if (w_rd_word < c_W_CFG_END) begin
            for (int k = 0; k < REG_ENTRIES; k++) begin
                if (w_rd_idx == WORD_W'(k)) w_rd_data = 32'(r_cfg[k]);
            end
        end else begin
            w_rd_err = 1'b1;
        end
    end

    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_aresetn) begin
            r_rdata  <= '0;
            r_rresp  <= c_RESP_OKAY;
            r_rd_pop <= 1'b0;
        end else if (w_rd_latch) begin
            r_rdata  <= w_rd_data;
            r_rresp  <= w_rd_err ? c_RESP_SLVERR : c_RESP_OKAY;
            // Decide now whether this response pops; only reads pop, so the
            // queue cannot drain between latch and handshake
            r_rd_pop <= (w_rd_word == c_W_MH_ID) && !w_fifo_empty;
        end
    end

    assign w_pop = w_rd_done && r_rd_pop;

    // ------------------------------------------------------- miss arbitration
    always_comb begin
        int   v_idx;
        logic v_found;
        v_found     = 1'b0;
        w_grant_idx = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            v_idx = int'(r_rr_ptr) + i;
            if (v_idx >= N_PORTS) v_idx = v_idx - N_PORTS;
            if (!v_found && MissValid_SI[v_idx]) begin
                v_found     = 1'b1;
                w_grant_idx = PW'(v_idx);
            end
        end
        // A full FIFO blocks the grant even if a pop frees a slot this cycle
        w_push = v_found && !w_fifo_full;
        for (int i = 0; i < N_PORTS; i++) begin
            MissReady_SO[i] = w_push && (w_grant_idx == PW'(i));
        end
    end

    assign w_push_entry.port = w_grant_idx;
    assign w_push_entry.id   = MissId_DI[w_grant_idx];
    assign w_push_entry.addr = MissAddr_DI[w_grant_idx][AXI_ADDR_WIDTH-1 -: MHR_WIDTH];
    assign w_overflow        = (|MissValid_SI) && w_fifo_full;

    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_aresetn) begin
            r_rr_ptr <= '0;
            r_sticky <= 1'b0;
            r_irq_en <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            if (w_push) begin
                r_rr_ptr <= (w_grant_idx == PW'(N_PORTS - 1)) ? '0 : w_grant_idx + 1'b1;
            end
            // A new overflow outranks a simultaneous software clear
            if (w_overflow)                                   r_sticky <= 1'b1;
            else if (w_stat_wr && r_wdata[c_STAT_STICKY_BIT]) r_sticky <= 1'b0;
            if (w_stat_wr) r_irq_en <= r_wdata[c_STAT_IRQEN_BIT];
            r_irq <= r_irq_en && !w_fifo_empty;
        end
    end

    assign MhIrq_SO      = r_irq;
    assign MhFifoFull_SO = w_fifo_full;

    rab_mh_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (MH_FIFO_DEPTH)
    ) u_mh_fifo (
        .clk     (s_axi_aclk),
        .rst_n   (s_axi_aresetn),
        .i_push  (w_push),
        .i_data  (w_push_entry),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    // Byte-lane address bits and low miss-address bits carry no information here
    assign w_unused = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0], MissAddr_DI};

endmodule
`default_nettype wire
